// File: rtl/icache_sa.sv
// icache_sa: N-way set-associative instruction cache with multi-word lines and a line-refill engine.
// Defining ICACHE_FLUSH_EN adds the flush port and the deferred invalidate-all logic.
module icache_sa #(
    parameter int unsigned WAYS       = 4,
    parameter int unsigned SETS       = 64,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [31:0]       resp_data,
    output logic              resp_hit,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    input  logic [31:0]       mem_resp_data
`ifdef ICACHE_FLUSH_EN
    ,
    input  logic              flush
`endif
);

    localparam int unsigned WORD_W = $clog2(LINE_WORDS);
    localparam int unsigned OFF_W  = WORD_W + 2;
    localparam int unsigned IDX_W  = $clog2(SETS);
    localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int unsigned WAY_W  = $clog2(WAYS);

    // Handshakes: a transfer occurs on a rising edge where valid and ready are both high;
    // the side raising valid holds it and its payload stable until that edge.
    typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, REFILL, RESP} state_t;
    state_t state_q, state_d;

    // Address is kept without its byte-offset bits, which fetch never uses.
    logic [ADDR_W-3:0] addr_q;
    logic [TAG_W-1:0]  tag_q;
    logic [IDX_W-1:0]  idx_q;
    logic [WORD_W-1:0] word_q;
    logic              unused_addr_bits;

    assign tag_q            = addr_q[ADDR_W-3 -: TAG_W];
    assign idx_q            = addr_q[OFF_W-2 +: IDX_W];
    assign word_q           = addr_q[0 +: WORD_W];
    assign unused_addr_bits = ^req_addr[1:0];

    logic [TAG_W-1:0]           tag_mem  [WAYS][SETS];
    logic [31:0]                data_mem [WAYS][SETS*LINE_WORDS];
    logic [SETS-1:0][WAYS-1:0]  valid_q;
    logic [SETS-1:0][WAY_W-1:0] ptr_q;

    logic [WORD_W-1:0] cnt_q;
    logic [WAY_W-1:0]  victim_q, victim_d;
    logic              use_rr_q, inv_found;
    logic [31:0]       cap_q;
    logic              hit;
    logic [31:0]       hit_word;
    logic              flush_pend, flush_apply;
    logic              refill_beat, last_beat;

    assign refill_beat = (state_q == REFILL) && mem_resp_valid;
    assign last_beat   = refill_beat && (&cnt_q);

    always_comb begin
        hit      = 1'b0;
        hit_word = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx_q][w] && (tag_mem[w][idx_q] == tag_q)) begin
                hit      = 1'b1;
                hit_word = data_mem[w][{idx_q, word_q}];
            end
        end
    end

    // Lowest-index invalid way wins; the round-robin pointer is only the fallback.
    always_comb begin
        inv_found = 1'b0;
        victim_d  = ptr_q[idx_q];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx_q][w]) begin
                inv_found = 1'b1;
                victim_d  = WAY_W'(w);
            end
        end
    end

`ifdef ICACHE_FLUSH_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            flush_pend <= 1'b0;
        else if (flush)
            flush_pend <= 1'b1;
        else if (flush_apply)
            flush_pend <= 1'b0;
    end
`else
    assign flush_pend = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        resp_hit      = 1'b0;
        resp_data     = '0;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        flush_apply   = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush_pend) begin
                    flush_apply = 1'b1;
                end else begin
                    req_ready = 1'b1;
                    if (req_valid) state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    resp_valid = 1'b1;
                    resp_hit   = 1'b1;
                    resp_data  = hit_word;
                    if (flush_pend) begin
                        flush_apply = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        req_ready = 1'b1;
                        state_d   = req_valid ? LOOKUP : IDLE;
                    end
                end else begin
                    flush_apply = flush_pend;
                    state_d     = MISS_REQ;
                end
            end
            MISS_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {tag_q, idx_q, OFF_W'(0)};
                if (mem_req_ready) state_d = REFILL;
            end
            REFILL: begin
                if (last_beat) state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_data  = cap_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            victim_q <= '0;
            use_rr_q <= 1'b0;
            cap_q    <= '0;
            valid_q  <= '0;
            ptr_q    <= '0;
        end else begin
            state_q <= state_d;
            if (req_valid && req_ready)
                addr_q <= req_addr[ADDR_W-1:2];
            if (flush_apply) begin
                valid_q <= '0;
                ptr_q   <= '0;
            end
            // Victim is frozen at the memory handshake so a flush in LOOKUP is already visible.
            if (state_q == MISS_REQ && mem_req_ready) begin
                cnt_q    <= '0;
                victim_q <= victim_d;
                use_rr_q <= ~inv_found;
            end
            if (refill_beat) begin
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == word_q)
                    cap_q <= mem_resp_data;
                if (last_beat) begin
                    valid_q[idx_q][victim_q] <= 1'b1;
                    if (use_rr_q)
                        ptr_q[idx_q] <= ptr_q[idx_q] + 1'b1;
                end
            end
        end
    end

    // Storage arrays carry no reset; the valid bits alone decide what is visible.
    always_ff @(posedge clk) begin
        if (refill_beat) begin
            data_mem[victim_q][{idx_q, cnt_q}] <= mem_resp_data;
            if (last_beat)
                tag_mem[victim_q][idx_q] <= tag_q;
        end
    end

endmodule

// File: tb/tb_icache_sa.sv
// tb_icache_sa: randomized bench for icache_sa against a line-level cache model and a backing memory.
// Flush scenarios are exercised only when ICACHE_FLUSH_EN is defined.
module tb_icache_sa;

    localparam int WAYS     = 4;
    localparam int SETS     = 64;
    localparam int LW       = 4;
    localparam int ADDR_W   = 32;
    localparam int LINE_B   = LW * 4;
    localparam int MAX_WAIT = 200;

    logic        clk, reset;
    logic        req_valid, req_ready, resp_valid, resp_hit;
    logic [31:0] req_addr, resp_data;
    logic        mem_req_valid, mem_req_ready, mem_resp_valid;
    logic [31:0] mem_req_addr, mem_resp_data;
`ifdef ICACHE_FLUSH_EN
    logic        flush;
`endif

    icache_sa #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LW), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .resp_hit       (resp_hit),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
`ifdef ICACHE_FLUSH_EN
        ,
        .flush          (flush)
`endif
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / checking ----------------
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];   // expected line addresses of memory requests

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- backing memory ----------------
    logic [31:0] backing [logic [31:0]];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (backing.exists(a)) return backing[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    // ---------------- reference model: set-associative cache of whole lines ----------------
    logic        m_valid [SETS][WAYS];
    logic [31:0] m_line  [SETS][WAYS];
    logic [31:0] m_data  [SETS][WAYS][LW];
    int          m_ptr   [SETS];

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
        end
    endtask

    task automatic model_access(input logic [31:0] a, output logic hit, output logic [31:0] data);
        int          s, wd, v;
        logic [31:0] line;
        line = a & ~(32'(LINE_B) - 32'd1);
        s    = int'((a / 32'(LINE_B)) % 32'(SETS));
        wd   = int'((a / 32'd4) % 32'(LW));
        hit  = 1'b0;
        data = '0;
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_line[s][w] == line) begin
                hit  = 1'b1;
                data = m_data[s][w][wd];
            end
        if (!hit) begin
            v = -1;
            for (int w = 0; w < WAYS; w++)
                if (!m_valid[s][w] && v < 0) v = w;
            if (v < 0) begin
                v        = m_ptr[s];
                m_ptr[s] = (m_ptr[s] + 1) % WAYS;
            end
            m_valid[s][v] = 1'b1;
            m_line[s][v]  = line;
            for (int i = 0; i < LW; i++) m_data[s][v][i] = mem_word(line + 32'(4 * i));
            data = m_data[s][v][wd];
            exp_q.push_back(line);
        end
    endtask

    // ---------------- memory responder ----------------
    int   stall_cfg   = 0;   // negative: random stall
    int   gap_max     = 0;
    bit   noise_en    = 1'b0;
    bit   stall_chk   = 1'b0;
    int   abort_after = -1;
    bit   aborted     = 1'b0;

    initial begin : mem_model
        logic [31:0] line;
        int          n, g;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        forever begin
            @(negedge clk);
            if (reset && mem_req_valid) begin
                mem_resp_valid = 1'b0;
                mem_req_ready  = 1'b0;
                line = mem_req_addr;
                if (exp_q.size() == 0) check_eq("mem_req_expected", 32'(exp_q.size()), 32'd1);
                else                   check_eq("mem_req_addr", mem_req_addr, exp_q.pop_front());
                n = (stall_cfg < 0) ? int'($urandom_range(0, 3)) : stall_cfg;
                for (int i = 0; i < n; i++) begin
                    if (stall_chk) begin
                        check_eq("stall_mem_req_valid", 32'(mem_req_valid), 32'd1);
                        check_eq("stall_mem_req_addr", mem_req_addr, line);
                        check_eq("stall_req_ready", 32'(req_ready), 32'd0);
                    end
                    @(negedge clk);
                end
                mem_req_ready = 1'b1;
                @(negedge clk);
                mem_req_ready = 1'b0;
                for (int b = 0; b < LW; b++) begin
                    g = int'($urandom_range(0, gap_max));
                    mem_resp_valid = 1'b0;
                    repeat (g) @(negedge clk);
                    if (b == abort_after) begin
                        aborted = 1'b1;
                        break;
                    end
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = mem_word(line + 32'(4 * b));
                    @(negedge clk);
                end
                mem_resp_valid = 1'b0;
            end else begin
                mem_req_ready  = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
                mem_resp_valid = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
                mem_resp_data  = $urandom;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_eq("rst_req_ready", 32'(req_ready), 32'd1);
            check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
            check_eq("rst_resp_hit", 32'(resp_hit), 32'd0);
            check_eq("rst_resp_data", resp_data, 32'd0);
            check_eq("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
            check_eq("rst_mem_req_addr", mem_req_addr, 32'd0);
        end
        model_reset();
        exp_q.delete();
        reset = 1'b1;
    endtask

    task automatic fetch(input logic [31:0] a, output logic got_hit, output logic [31:0] got_data,
                         output int lat);
        logic        exp_hit;
        logic [31:0] exp_d;
        int          n;
        model_access(a, exp_hit, exp_d);
        req_valid = 1'b1;
        req_addr  = a;
        n = 0;
        while (!req_ready && n < MAX_WAIT) begin
            @(negedge clk);
            n++;
        end
        check_eq("accept_in_bound", 32'(n < MAX_WAIT), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        lat = 1;
        while (!resp_valid && lat < MAX_WAIT) begin
            @(negedge clk);
            lat++;
        end
        got_hit  = resp_hit;
        got_data = resp_data;
        check_eq("resp_valid", 32'(resp_valid), 32'd1);
        check_eq("resp_hit", 32'(resp_hit), 32'(exp_hit));
        check_eq("resp_data", resp_data, exp_d);
        if (exp_hit) check_eq("hit_latency", 32'(lat), 32'd1);
        else         check_eq("miss_latency_min", 32'(lat >= LW + 3), 32'd1);
        check_eq("mem_req_drained", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check_eq("resp_single_cycle", 32'(resp_valid), 32'd0);
    endtask

    // Back-to-back accepts within one resident line; one response per cycle.
    task automatic stream(input logic [31:0] base, input int n);
        logic [31:0] addrs [8];
        logic [31:0] ed    [8];
        logic        eh    [8];
        for (int k = 0; k < n; k++) begin
            addrs[k] = base + 32'(4 * (k % LW));
            model_access(addrs[k], eh[k], ed[k]);
        end
        req_valid = 1'b1;
        req_addr  = addrs[0];
        for (int k = 0; k < n; k++) begin
            check_eq("stream_req_ready", 32'(req_ready), 32'd1);
            @(negedge clk);
            check_eq("stream_resp_valid", 32'(resp_valid), 32'd1);
            check_eq("stream_resp_hit", 32'(resp_hit), 32'(eh[k]));
            check_eq("stream_resp_data", resp_data, ed[k]);
            if (k + 1 < n) req_addr = addrs[k + 1];
            else           req_valid = 1'b0;
        end
        @(negedge clk);
        check_eq("stream_end_idle", 32'(resp_valid), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic        h;
        logic [31:0] d;
        logic [31:0] a;
        int          lat, n;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
`ifdef ICACHE_FLUSH_EN
        flush     = 1'b0;
`endif
        model_reset();
        #2;
        apply_reset();

        // cold miss, then hit in the same line
        for (int i = 0; i < LW; i++) backing[32'h1000 + 32'(4 * i)] = 32'hA0 + 32'(i);
        fetch(32'h0000_1004, h, d, lat);
        check_eq("cold_hit_flag", 32'(h), 32'd0);
        check_eq("cold_data", d, 32'h0000_00A1);
        check_eq("cold_latency", 32'(lat), 32'(LW + 3));
        fetch(32'h0000_1008, h, d, lat);
        check_eq("warm_hit_flag", 32'(h), 32'd1);
        check_eq("warm_data", d, 32'h0000_00A2);
        check_eq("warm_latency", 32'(lat), 32'd1);

        // replacement within one set
        apply_reset();
        fetch(32'h0000_0000, h, d, lat); check_eq("repl_fill0", 32'(h), 32'd0);
        fetch(32'h0000_0400, h, d, lat); check_eq("repl_fill1", 32'(h), 32'd0);
        fetch(32'h0000_0800, h, d, lat); check_eq("repl_fill2", 32'(h), 32'd0);
        fetch(32'h0000_0C00, h, d, lat); check_eq("repl_fill3", 32'(h), 32'd0);
        fetch(32'h0000_1000, h, d, lat); check_eq("repl_evict", 32'(h), 32'd0);
        fetch(32'h0000_0400, h, d, lat); check_eq("repl_kept_hit", 32'(h), 32'd1);
        fetch(32'h0000_0000, h, d, lat); check_eq("repl_evicted_miss", 32'(h), 32'd0);

        // memory request stall
        stall_cfg = 5;
        stall_chk = 1'b1;
        fetch(32'h0000_3008, h, d, lat);
        check_eq("stall_hit_flag", 32'(h), 32'd0);
        check_eq("stall_latency", 32'(lat), 32'(LW + 3 + 5));
        stall_cfg = 0;
        stall_chk = 1'b0;

        // reset in the middle of a refill
        abort_after = 2;
        aborted     = 1'b0;
        model_access(32'h0000_2000, h, d);
        req_valid = 1'b1;
        req_addr  = 32'h0000_2000;
        n = 0;
        while (!req_ready && n < MAX_WAIT) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!aborted && n < MAX_WAIT) begin @(negedge clk); n++; end
        check_eq("abort_reached", 32'(aborted), 32'd1);
        apply_reset();
        abort_after = -1;
        fetch(32'h0000_2000, h, d, lat);
        check_eq("rst_refill_miss", 32'(h), 32'd0);

        // streaming hits
        fetch(32'h0000_5000, h, d, lat);
        stream(32'h0000_5000, 8);

`ifdef ICACHE_FLUSH_EN
        fetch(32'h0000_1000, h, d, lat);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        model_reset();
        fetch(32'h0000_1000, h, d, lat);
        check_eq("flush_then_miss", 32'(h), 32'd0);
        fork
            fetch(32'h0000_6004, h, d, lat);
            begin
                repeat (5) @(negedge clk);
                flush = 1'b1;
                @(negedge clk);
                flush = 1'b0;
            end
        join
        check_eq("flush_refill_resp", 32'(h), 32'd0);
        model_reset();
        fetch(32'h0000_6004, h, d, lat);
        check_eq("flush_refill_line_miss", 32'(h), 32'd0);
`endif

        // randomized traffic with memory stalls, beat gaps and idle-time noise
        noise_en  = 1'b1;
        stall_cfg = -1;
        gap_max   = 2;
        for (int it = 0; it < 150; it++) begin
            a = ($urandom_range(0, 7) << 10) | ($urandom_range(0, 3) << 4) |
                ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            fetch(a, h, d, lat);
            if ($urandom_range(0, 4) == 0)
                stream(a & ~(32'(LINE_B) - 32'd1), int'($urandom_range(2, 6)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        noise_en = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/icache_sa.md
# icache_sa

Parametrised N-way set-associative instruction cache with multi-word lines and a line-refill engine. It sits between the fetch stage and the instruction memory port. It returns hits one cycle after request acceptance. On a miss it fetches a full line through a valid/ready request and beat-by-beat response interface, then returns the requested word. It replaces the fixed 4-way, single-word, refill-less cache.

## Interface
- WAYS, 4, associativity (power of 2, ≥2)
- SETS, 64, number of sets (power of 2)
- LINE_WORDS, 4, 32-bit words per line (power of 2, ≥2)
- ADDR_W, 32, address width
- Derived: OFF_W=log2(LINE_WORDS)+2, IDX_W=log2(SETS), TAG_W=ADDR_W-IDX_W-OFF_W (defaults 4/6/22)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  fetch request
- req_addr  in  ADDR_W  PC, word aligned; bits [1:0] ignored
- req_ready  out  1  request accepted when req_valid && req_ready
- resp_valid  out  1  resp_data valid this cycle (no backpressure)
- resp_data  out  32  instruction word
- resp_hit  out  1  qualifies resp_valid: 1 = hit, 0 = refill response
- mem_req_valid  out  1  line fetch request
- mem_req_addr  out  ADDR_W  line-aligned address, low OFF_W bits 0
- mem_req_ready  in  1  memory accepts request
- mem_resp_valid  in  1  one refill beat present
- mem_resp_data  in  32  refill word, beats in order word 0..LINE_WORDS-1
- flush  in  1  invalidate all lines (only with ICACHE_FLUSH_EN)

## Operation
- Address split: tag = [ADDR_W-1:IDX_W+OFF_W], idx = [IDX_W+OFF_W-1:OFF_W], word = [OFF_W-1:2].
- Storage: per way, a tag array, a valid bit per set, and a data array of SETS×LINE_WORDS words. Per set, a round-robin pointer of log2(WAYS) bits.
- FSM states:
  - IDLE: req_ready=1. On accept, register the address and go to LOOKUP.
  - LOOKUP: compare the registered tag against all ways at the registered idx.
    - Hit: resp_valid=1, resp_hit=1, resp_data = word from the hitting way. req_ready=1, so a new accept goes to LOOKUP again; no accept goes to IDLE.
    - Miss: req_ready=0, go to MISS_REQ.
  - MISS_REQ: mem_req_valid=1, mem_req_addr = line address, both held stable until mem_req_ready. On handshake, clear the beat counter and go to REFILL.
  - REFILL: each mem_resp_valid beat writes the victim way's data at the beat counter and increments the counter. The beat matching the requested word is captured. After the last beat, write the tag and set valid=1, advance the set's pointer, and go to RESP.
  - RESP: resp_valid=1, resp_hit=0, resp_data = captured word. Go to IDLE.
- req_ready=0 in MISS_REQ, REFILL and RESP.
- Victim selection: lowest-index invalid way if any. Otherwise the round-robin pointer, which wraps from WAYS-1 to 0. The pointer advances only when the fill used it.
- At most one way hits; tags are unique per set by construction.
- mem_resp_valid outside REFILL is ignored. mem_req_ready outside MISS_REQ is ignored.
- The valid bit is set only after the final beat, so a partial line is never visible.

## Timing
- Reset values: state IDLE, all valid bits 0, pointers 0.
- Outputs during reset: req_ready=1, resp_valid=0, resp_hit=0, resp_data=0, mem_req_valid=0, mem_req_addr=0.
- Hit latency: accept in cycle N, response in cycle N+1. Back-to-back hits sustain one response per cycle.
- Miss latency: accept N, LOOKUP N+1, mem_req_valid from N+2. Memory handshake in cycle H. Last beat in cycle B. resp_valid in B+1. Minimum N+2+LINE_WORDS+1 with zero-wait memory.
- Reset mid-refill: abandon immediately, return to IDLE. The partially written line stays invalid.

## Configuration
- ICACHE_FLUSH_EN defined:
  - The flush port exists. A flush sampled high sets a pending flag.
  - The flag is applied in the first cycle the FSM is in IDLE, or in LOOKUP with no accept.
  - In that cycle all valid bits and pointers clear, and req_ready=0.
  - A refill in progress completes and responds first; its line is then invalidated.
- ICACHE_FLUSH_EN undefined: no flush port; valid bits clear only on reset.

## Test plan
- Cold miss then hit: req 0x0000_1004 → mem_req_addr 0x0000_1000. Beats 0xA0,0xA1,0xA2,0xA3 → resp_data 0xA1, resp_hit 0. Then req 0x0000_1008 → resp_data 0xA2, resp_hit 1, one cycle after accept.
- Replacement: fill 0x0000, 0x0400, 0x0800, 0x0C00 (same set, ways 0–3). Fill 0x1000 evicts way 0. Then req 0x0000 misses and req 0x0400 hits.
- Memory stall: mem_req_ready low for 5 cycles → mem_req_valid=1 with mem_req_addr constant, and req_ready=0, for all 5 cycles. Data arrives correctly after the stall.
- Reset after 2 of 4 refill beats of 0x2000 → after reset, req 0x2000 misses and a new mem_req is issued.
- Streaming hits: 8 consecutive accepts within one filled line → resp_valid high 8 consecutive cycles with correct words.
- (ICACHE_FLUSH_EN) Flush after filling 0x1000 → next req 0x1000 misses. Flush during REFILL → refill response still delivered, and the following req to that line misses.
